// File: rtl/finger_status_conditioner.sv
// Turns serial per-finger flex ADC samples into five debounced bent/straight status bits.
// Latency: finger 4 accepted at edge k -> statuses and status_valid updated at edge k+1.
// Backpressure: sample_ready drops for the single UPDATE cycle after each complete frame and during reset.
module finger_status_conditioner #(
  parameter int ADC_W = 10,
  parameter int TH_HI = 600,
  parameter int TH_LO = 400,
  parameter int DEB_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic [2:0]       sample_finger,
  input  logic [ADC_W-1:0] sample_data,
  output logic             thumb_status,
  output logic             index_status,
  output logic             middle_status,
  output logic             ring_status,
  output logic             pinky_status,
  output logic             status_valid,
  output logic             frame_error
);

  localparam int CW = $clog2(DEB_N);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEB_N - 1);
  localparam logic [ADC_W-1:0] HI      = ADC_W'(TH_HI);
  localparam logic [ADC_W-1:0] LO      = ADC_W'(TH_LO);

  typedef enum logic {COLLECT, UPDATE} state_t;
  typedef enum logic [1:0] {CLS_HOLD, CLS_BENT, CLS_STRAIGHT} cls_t;

  state_t        state;
  logic [2:0]    exp_idx;
  cls_t          shadow [5];
  logic [4:0]    raw;
  logic [4:0]    status;
  logic [CW-1:0] cnt [5];

  logic          accept;
  logic          in_order;
  cls_t          sample_cls;
  logic [4:0]    raw_nxt;
  logic [4:0]    status_nxt;
  logic [CW-1:0] cnt_nxt [5];

  assign sample_ready = (state == COLLECT) && !rst;
  assign accept       = sample_valid && sample_ready;
  assign in_order     = (sample_finger == exp_idx) && (sample_finger <= 3'd4);

  assign thumb_status  = status[0];
  assign index_status  = status[1];
  assign middle_status = status[2];
  assign ring_status   = status[3];
  assign pinky_status  = status[4];

  // Classify the incoming reading against the hysteresis thresholds; the band between them holds.
  always_comb begin
    sample_cls = CLS_HOLD;
    if (sample_data >= HI) begin
      sample_cls = CLS_BENT;
    end else if (sample_data <= LO) begin
      sample_cls = CLS_STRAIGHT;
    end
  end

  // Next raw/status/counter values for a committed frame; debounce looks at the freshly committed raw bit.
  always_comb begin
    raw_nxt    = raw;
    status_nxt = status;
    for (int i = 0; i < 5; i++) begin
      cnt_nxt[i] = cnt[i];
      if (shadow[i] == CLS_BENT) begin
        raw_nxt[i] = 1'b1;
      end else if (shadow[i] == CLS_STRAIGHT) begin
        raw_nxt[i] = 1'b0;
      end
      if (raw_nxt[i] == status[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        status_nxt[i] = raw_nxt[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  // Frame collection / commit FSM; pulses are registered and cleared every cycle by default.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      exp_idx      <= 3'd0;
      raw          <= 5'b0;
      status       <= 5'b0;
      status_valid <= 1'b0;
      frame_error  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= CLS_HOLD;
      end
    end else begin
      status_valid <= 1'b0;
      frame_error  <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (in_order) begin
              shadow[sample_finger] <= sample_cls;
              if (sample_finger == 3'd4) begin
                state   <= UPDATE;
                exp_idx <= 3'd0;
              end else begin
                exp_idx <= exp_idx + 3'd1;
              end
            end else begin
              // Partial shadow data is simply abandoned: a frame only commits once all five
              // fingers have been rewritten in order.
              frame_error <= 1'b1;
              if (sample_finger == 3'd0) begin
                shadow[0] <= sample_cls;
                exp_idx   <= 3'd1;
              end else begin
                exp_idx <= 3'd0;
              end
            end
          end
        end
        UPDATE: begin
          raw          <= raw_nxt;
          status       <= status_nxt;
          cnt          <= cnt_nxt;
          status_valid <= 1'b1;
          state        <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_finger_status_conditioner.sv
// Bench for finger_status_conditioner: directed scenarios followed by random sample streams,
// all compared against a frame-level reference model of hysteresis and debounce.
module tb_finger_status_conditioner;

  localparam int ADC_W = 10;
  localparam int TH_HI = 600;
  localparam int TH_LO = 400;
  localparam int DEB_N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_valid = 1'b0;
  logic             sample_ready;
  logic [2:0]       sample_finger = 3'd0;
  logic [ADC_W-1:0] sample_data = '0;
  logic             thumb_status, index_status, middle_status, ring_status, pinky_status;
  logic             status_valid, frame_error;
  logic [4:0]       dut_st;

  finger_status_conditioner #(.ADC_W(ADC_W), .TH_HI(TH_HI), .TH_LO(TH_LO), .DEB_N(DEB_N)) dut (
    .clk(clk), .rst(rst),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_finger(sample_finger), .sample_data(sample_data),
    .thumb_status(thumb_status), .index_status(index_status), .middle_status(middle_status),
    .ring_status(ring_status), .pinky_status(pinky_status),
    .status_valid(status_valid), .frame_error(frame_error)
  );

  assign dut_st = {pinky_status, ring_status, middle_status, index_status, thumb_status};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected finger, pending class per finger (0 hold, 1 bent, 2 straight),
  // committed raw level, reported status and current disagreement run length per finger.
  int exp_m;
  int sh    [5];
  int raw_m [5];
  int st_m  [5];
  int run_m [5];
  int bias  [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int cls(input int d);
    if (d >= TH_HI) return 1;
    if (d <= TH_LO) return 2;
    return 0;
  endfunction

  function automatic void model_reset();
    exp_m = 0;
    for (int i = 0; i < 5; i++) begin
      sh[i] = 0; raw_m[i] = 0; st_m[i] = 0; run_m[i] = 0;
    end
  endfunction

  // A status flips once the raw level has disagreed with it for DEB_N frames in a row.
  function automatic void commit();
    for (int i = 0; i < 5; i++) begin
      if (sh[i] == 1) raw_m[i] = 1;
      else if (sh[i] == 2) raw_m[i] = 0;
      if (raw_m[i] == st_m[i]) begin
        run_m[i] = 0;
      end else begin
        run_m[i] = run_m[i] + 1;
        if (run_m[i] == DEB_N) begin
          st_m[i]  = raw_m[i];
          run_m[i] = 0;
        end
      end
    end
  endfunction

  function automatic logic [4:0] stvec();
    logic [4:0] v;
    for (int i = 0; i < 5; i++) v[i] = (st_m[i] != 0);
    return v;
  endfunction

  task automatic send(input int f, input int d);
    int  waited;
    bit  err;
    @(negedge clk);
    sample_valid  = 1'b1;
    sample_finger = 3'(f);
    sample_data   = ADC_W'(d);
    waited = 0;
    while (!sample_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      sample_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    err = (f > 4) || (f != exp_m);
    if (!err) begin
      sh[f] = cls(d);
      exp_m = (f == 4) ? 0 : exp_m + 1;
    end else if (f == 0) begin
      sh[0] = cls(d);
      exp_m = 1;
    end else begin
      exp_m = 0;
    end
    chk("frame_error", frame_error, err);
    if (!err && f == 4) begin
      chk("ready_in_update", sample_ready, 0);
      chk("sv_before_commit", status_valid, 0);
      commit();
      @(posedge clk);
      #1;
      chk("status_valid", status_valid, 1);
      chk("status", dut_st, stvec());
      chk("no_ferr_with_sv", frame_error, 0);
    end else begin
      chk("sv_idle", status_valid, 0);
    end
  endtask

  task automatic frame(input int d0, input int d1, input int d2, input int d3, input int d4);
    send(0, d0); send(1, d1); send(2, d2); send(3, d3); send(4, d4);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_status"}, dut_st, 0);
    chk({tag, "_ready"}, sample_ready, 0);
    chk({tag, "_sv"}, status_valid, 0);
    chk({tag, "_ferr"}, frame_error, 0);
  endtask

  initial begin
    int f, d;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", sample_ready, 1);

    // Four bent frames: statuses flip only on the fourth
    for (int k = 0; k < 4; k++) begin
      frame(700, 700, 700, 700, 700);
      chk("bent_run", dut_st, (k == 3) ? 5'b11111 : 5'b00000);
    end

    // Thumb parked in the hold band stays bent
    for (int k = 0; k < 6; k++) frame(500, 700, 700, 700, 700);
    chk("hold_band", dut_st, 5'b11111);

    // Thumb straight x3, interrupted by bent, then straight x4
    for (int k = 0; k < 3; k++) frame(300, 700, 700, 700, 700);
    frame(700, 700, 700, 700, 700);
    for (int k = 0; k < 3; k++) frame(300, 700, 700, 700, 700);
    chk("thumb_not_yet", thumb_status, 1);
    frame(300, 700, 700, 700, 700);
    chk("thumb_flipped", thumb_status, 0);

    // Threshold boundaries: exactly TH_LO straight, exactly TH_HI bent, just inside hold
    for (int k = 0; k < 4; k++) frame(600, 400, 401, 599, 700);
    chk("boundaries", dut_st, 5'b11101);

    // Ordering errors: 0,1,3 then a clean frame; 0,1,0 restarts a frame
    send(0, 300); send(1, 300); send(3, 300);
    frame(700, 700, 700, 700, 700);
    send(0, 300); send(1, 300); send(0, 700);
    send(2, 700); send(3, 700); send(4, 700);
    send(7, 100);
    send(4, 100);

    // sample_valid held through UPDATE is not taken until COLLECT resumes
    send(0, 700); send(1, 700); send(2, 700); send(3, 700);
    @(negedge clk);
    sample_valid  = 1'b1;
    sample_finger = 3'd4;
    sample_data   = ADC_W'(700);
    chk("ready_before_f4", sample_ready, 1);
    @(posedge clk);
    #1;
    sh[4] = cls(700);
    exp_m = 0;
    sample_finger = 3'd0;
    chk("held_ready_low", sample_ready, 0);
    commit();
    @(posedge clk);
    #1;
    chk("held_sv", status_valid, 1);
    chk("held_status", dut_st, stvec());
    chk("held_ready_high", sample_ready, 1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    sh[0] = cls(700);
    exp_m = 1;
    chk("held_accept_ferr", frame_error, 0);
    send(1, 700); send(2, 700); send(3, 700); send(4, 700);

    // Reset in the middle of a frame
    send(0, 100); send(1, 100); send(2, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("midframe_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    frame(700, 700, 700, 700, 700);
    chk("after_rst_frame", dut_st, 5'b00000);
    for (int k = 0; k < 3; k++) frame(700, 700, 700, 700, 700);
    chk("after_rst_cnt", dut_st, 5'b11111);

    // Random sample streams with biased levels and occasional bad indices
    for (int i = 0; i < 5; i++) bias[i] = $urandom_range(0, 1);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < 5; i++) bias[i] = $urandom_range(0, 1);
      end
      f = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : exp_m;
      case ($urandom_range(0, 5))
        0: d = $urandom_range(0, 1023);
        1: d = $urandom_range(TH_LO - 1, TH_LO + 1);
        2: d = $urandom_range(TH_HI - 1, TH_HI + 1);
        default: d = (f < 5 && bias[f % 5] != 0) ? 700 + int'($urandom_range(0, 300)) : int'($urandom_range(0, 350));
      endcase
      send(f, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/finger_status_conditioner.md
Name: finger_status_conditioner

Overview:
- Upstream stage of the sign identification block.
- Converts per-finger flex-sensor ADC samples into the five debounced bent/straight status bits that sign identification consumes.
- Samples arrive serially, one finger per handshake, in frame order thumb..pinky (index 0..4).
- Per frame: applies threshold hysteresis, then multi-frame debounce, then emits one status_valid strobe with the updated status bits.

Parameters:
ADC_W, 10, sample width in bits
TH_HI, 600, raw reading >= TH_HI classifies finger as bent
TH_LO, 400, raw reading <= TH_LO classifies finger as straight; TH_LO < TH_HI required
DEB_N, 4, consecutive frames of disagreement needed to flip a status (2..15)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, synchronous, active-high
sample_valid  input  1  sample_finger/sample_data valid this cycle
sample_ready  output  1  block can accept a sample this cycle
sample_finger  input  3  finger index, 0=thumb .. 4=pinky
sample_data  input  ADC_W  unsigned flex reading
thumb_status  output  1  debounced status, 1=bent
index_status  output  1  debounced status, 1=bent
middle_status  output  1  debounced status, 1=bent
ring_status  output  1  debounced status, 1=bent
pinky_status  output  1  debounced status, 1=bent
status_valid  output  1  one-cycle pulse: status bits just updated for a complete frame
frame_error  output  1  one-cycle pulse: out-of-order or illegal finger index seen

Behaviour:
- Reset values:
  - all *_status = 0
  - status_valid = 0, frame_error = 0
  - hysteresis bits = 0, debounce counters = 0, expected index = 0, state = COLLECT
  - sample_ready = 0 while rst is high
- Accept: sample accepted on an edge where sample_valid && sample_ready.
- FSM states: COLLECT, UPDATE.
- COLLECT:
  - sample_ready = 1.
  - Accepted sample with sample_finger == expected index: compute class (bent / straight / hold) against TH_HI/TH_LO; store in a per-finger shadow register; expected index +1.
  - Acceptance of finger 4 -> UPDATE, expected index -> 0.
  - Accepted sample with sample_finger != expected index, or sample_finger > 4:
    - frame_error pulses high the next cycle; shadow contents discarded.
    - If sample_finger == 0, it is taken as the start of a new frame (stored, expected index -> 1); otherwise expected index -> 0.
- UPDATE (exactly one cycle):
  - sample_ready = 0; sample_valid is ignored, nothing is accepted.
  - Per finger i, hysteresis commit:
    - shadow class bent -> raw[i] = 1
    - shadow class straight -> raw[i] = 0
    - shadow class hold -> raw[i] unchanged
  - Per finger i, debounce, using the new raw[i]:
    - raw[i] == status[i] -> cnt[i] = 0
    - else if cnt[i] == DEB_N-1 -> status[i] = raw[i], cnt[i] = 0
    - else cnt[i] = cnt[i] + 1
  - All five statuses commit on the edge leaving UPDATE. status_valid is high for the cycle after that edge, coincident with the new status values.
  - Next state is COLLECT.
- Latency: finger 4 accepted at edge k -> statuses updated at edge k+1 -> status_valid high during cycle k+1..k+2.
- Aborted frames have no effect on raw, cnt or status; only a completed frame commits.
- Boundary cases:
  - Values strictly between TH_LO and TH_HI never change raw.
  - Exactly TH_HI classifies bent; exactly TH_LO classifies straight.
  - Debounce counter width is clog2(DEB_N); it never exceeds DEB_N-1.
- rst asserted mid-frame or during UPDATE: all state returns to reset values on that edge; no status_valid or frame_error pulse is generated for the interrupted frame.
- status_valid and frame_error are never high in the same cycle.

Test Plan:
- Reset, then 4 frames with all fingers = 700 (DEB_N=4) -> status_valid pulses 4 times; statuses stay 00000 after frames 1-3, become 11111 after frame 4.
- From all bent: 6 frames with thumb = 500, others 700 -> thumb stays 1 throughout (hold band); cnt stays 0.
- From thumb bent: thumb = 300 for 3 frames, 700 for 1 frame, then 300 for 4 frames -> no change until the 4th frame of the final run, then thumb_status = 0.
- Sequence finger 0,1,3 -> frame_error pulse after finger 3, no status_valid; then 0..4 -> status_valid. Also sequence 0,1,0 -> frame_error, and the second 0 starts a new frame so only 2..4 are needed.
- sample_valid held high through UPDATE with finger 0 -> sample_ready = 0 that cycle, sample not accepted; accepted the next cycle.
- Assert rst after fingers 0..2 of a frame -> outputs return to 0, expected index = 0, no pulses; a following clean frame of all 700 increments every cnt to 1 and leaves statuses 00000.
